// File: rtl/sqr_sweep_ctrl.sv
// Sweep sequencer for the square-wave generator: latches a sweep configuration on
// start and steps the generator frequency word between two bounds with a fixed dwell.
module sqr_sweep_ctrl #(
  parameter int FREQ_W  = 12,
  parameter int DWELL_W = 16,
  parameter int AMP_W   = 3,
  parameter int PH_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [FREQ_W-1:0]  cfg_freq_start,
  input  logic [FREQ_W-1:0]  cfg_freq_stop,
  input  logic [FREQ_W-1:0]  cfg_freq_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic [AMP_W-1:0]   cfg_amp,
  input  logic [PH_W-1:0]    cfg_phase,
  output logic               gen_en,
  output logic [FREQ_W-1:0]  gen_freq,
  output logic [AMP_W-1:0]   gen_amp,
  output logic [PH_W-1:0]    gen_phase,
  output logic               busy,
  output logic               step_pulse,
  output logic               wrap_pulse,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state;
  logic [FREQ_W-1:0]  s_start, s_stop, s_step;
  logic [DWELL_W-1:0] s_dwell, cnt;
  logic [1:0]         s_mode;
  logic               dir_up;

  logic [FREQ_W-1:0]  lo, hi, dn_val;
  logic [FREQ_W:0]    up_sum;
  logic               up_out, dn_out;

  // Both directions are evaluated every cycle so a ping-pong reversal can
  // take the opposite-direction step in the same dwell expiry.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    lo     = s_start;
    hi     = s_stop;
    if (s_start > s_stop) begin
      lo = s_stop;
      hi = s_start;
    end
    up_sum = {1'b0, gen_freq} + {1'b0, s_step};
    up_out = up_sum > {1'b0, hi};
    dn_out = {1'b0, gen_freq} < ({1'b0, lo} + {1'b0, s_step});
    dn_val = gen_freq - s_step;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s_start    <= '0;
      s_stop     <= '0;
      s_step     <= '0;
      s_dwell    <= '0;
      s_mode     <= '0;
      dir_up     <= 1'b1;
      cnt        <= '0;
      gen_en     <= 1'b0;
      gen_freq   <= '0;
      gen_amp    <= AMP_W'(1);
      gen_phase  <= '0;
      busy       <= 1'b0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      done       <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state  <= IDLE;
        gen_en <= 1'b0;
        busy   <= 1'b0;
        cnt    <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            s_start   <= cfg_freq_start;
            s_stop    <= cfg_freq_stop;
            s_step    <= cfg_freq_step;
            s_dwell   <= cfg_dwell;
            s_mode    <= cfg_mode;
            dir_up    <= cfg_freq_start <= cfg_freq_stop;
            gen_freq  <= cfg_freq_start;
            gen_amp   <= (cfg_amp == '0) ? AMP_W'(1) : cfg_amp;
            gen_phase <= cfg_phase;
            gen_en    <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
            state     <= RUN;
          end
          RUN: begin
            if (cnt != s_dwell) begin
              cnt <= cnt + DWELL_W'(1);
            end else begin
              cnt <= '0;
              if (dir_up ? !up_out : !dn_out) begin
                gen_freq   <= dir_up ? up_sum[FREQ_W-1:0] : dn_val;
                step_pulse <= (s_step != '0);
              end else begin
                case (s_mode)
                  2'd1: begin
                    gen_freq   <= s_start;
                    wrap_pulse <= 1'b1;
                    step_pulse <= 1'b1;
                  end
                  2'd2: begin
                    dir_up     <= !dir_up;
                    wrap_pulse <= 1'b1;
                    if (dir_up ? !dn_out : !up_out) begin
                      gen_freq   <= dir_up ? dn_val : up_sum[FREQ_W-1:0];
                      step_pulse <= 1'b1;
                    end
                  end
                  default: begin
                    state  <= FINISH;
                    done   <= 1'b1;
                    gen_en <= 1'b0;
                    busy   <= 1'b0;
                  end
                endcase
              end
            end
          end
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sqr_sweep_ctrl.sv
// Scoreboard bench for sqr_sweep_ctrl: per-cycle expected output records are queued
// from the sweep description and compared on the falling edge.
module tb_sqr_sweep_ctrl;

  localparam int FREQ_W = 12, DWELL_W = 16, AMP_W = 3, PH_W = 8;

  logic               clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [FREQ_W-1:0]  cfg_freq_start = '0, cfg_freq_stop = '0, cfg_freq_step = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic [1:0]         cfg_mode = '0;
  logic [AMP_W-1:0]   cfg_amp = '0;
  logic [PH_W-1:0]    cfg_phase = '0;
  logic               gen_en, busy, step_pulse, wrap_pulse, done;
  logic [FREQ_W-1:0]  gen_freq;
  logic [AMP_W-1:0]   gen_amp;
  logic [PH_W-1:0]    gen_phase;

  int total = 0, bad = 0;
  logic [31:0] sb[$];

  sqr_sweep_ctrl #(.FREQ_W(FREQ_W), .DWELL_W(DWELL_W), .AMP_W(AMP_W), .PH_W(PH_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_freq_start(cfg_freq_start), .cfg_freq_stop(cfg_freq_stop),
    .cfg_freq_step(cfg_freq_step), .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
    .cfg_amp(cfg_amp), .cfg_phase(cfg_phase), .gen_en(gen_en), .gen_freq(gen_freq),
    .gen_amp(gen_amp), .gen_phase(gen_phase), .busy(busy), .step_pulse(step_pulse),
    .wrap_pulse(wrap_pulse), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Record layout: {en, busy, step, wrap, done, freq}
  function automatic logic [31:0] rec(input logic en, input logic bz, input logic st,
                                      input logic wr, input logic dn, input int f);
    return {15'b0, en, bz, st, wr, dn, f[11:0]};
  endfunction

  function automatic logic [31:0] observed();
    return {15'b0, gen_en, busy, step_pulse, wrap_pulse, done, gen_freq};
  endfunction

  task automatic hold(input int f, input int n, input logic st, input logic wr);
    sb.push_back(rec(1, 1, st, wr, 0, f));
    for (int i = 1; i < n; i++) sb.push_back(rec(1, 1, 0, 0, 0, f));
  endtask

  task automatic idle(input int f, input int n);
    for (int i = 0; i < n; i++) sb.push_back(rec(0, 0, 0, 0, 0, f));
  endtask

  task automatic finish_rec(input int f);
    sb.push_back(rec(0, 0, 0, 0, 1, f));
    sb.push_back(rec(0, 0, 0, 0, 0, f));
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n && sb.size() > 0; i++) begin
      @(negedge clk);
      check(tag, observed(), sb.pop_front());
    end
  endtask

  task automatic launch(input int mode, input int fs, input int fp, input int st,
                        input int dw, input int amp, input int ph);
    cfg_mode       = mode[1:0];
    cfg_freq_start = fs[11:0];
    cfg_freq_stop  = fp[11:0];
    cfg_freq_step  = st[11:0];
    cfg_dwell      = dw[15:0];
    cfg_amp        = amp[2:0];
    cfg_phase      = ph[7:0];
    start          = 1'b1;
  endtask

  task automatic run(input string tag);
    drain(tag, 1);
    start = 1'b0;
    drain(tag, sb.size());
  endtask

  initial begin
    // Reset state, idle for 10 cycles
    #12 rst_n = 1'b1;
    idle(0, 10);
    drain("reset_idle", 10);
    check("reset_amp", 32'(gen_amp), 32'd1);

    // Single shot, exact landing on stop
    launch(0, 100, 130, 10, 3, 2, 0);
    hold(100, 4, 0, 0); hold(110, 4, 1, 0); hold(120, 4, 1, 0); hold(130, 4, 1, 0);
    finish_rec(130);
    run("single_exact");

    // Single shot, stop not a multiple of step
    launch(0, 100, 125, 10, 0, 2, 0);
    hold(100, 1, 0, 0); hold(110, 1, 1, 0); hold(120, 1, 1, 0);
    finish_rec(120);
    run("single_inexact");

    // Top of range, no 12-bit wrap
    launch(0, 4095, 4095, 4095, 0, 2, 0);
    hold(4095, 1, 0, 0);
    finish_rec(4095);
    run("single_top");

    // Repeat, downward, then abort
    launch(1, 50, 30, 10, 0, 3, 0);
    hold(50, 1, 0, 0); hold(40, 1, 1, 0); hold(30, 1, 1, 0);
    hold(50, 1, 1, 1); hold(40, 1, 1, 0); hold(30, 1, 1, 0);
    hold(50, 1, 1, 1); hold(40, 1, 1, 0);
    run("repeat_down");
    abort = 1'b1;
    idle(40, 1);
    drain("repeat_abort", 1);
    abort = 1'b0;
    idle(40, 2);
    drain("repeat_abort_idle", 2);

    // Ping-pong 0..20 step 10
    launch(2, 0, 20, 10, 1, 1, 0);
    hold(0, 2, 0, 0); hold(10, 2, 1, 0); hold(20, 2, 1, 0);
    hold(10, 2, 1, 1); hold(0, 2, 1, 0); hold(10, 2, 1, 1); hold(20, 2, 1, 0);
    run("pingpong");
    abort = 1'b1;
    idle(20, 1);
    drain("pingpong_abort", 1);
    abort = 1'b0;

    // Ping-pong with range narrower than step: freq holds, wrap every dwell
    launch(2, 0, 5, 10, 0, 1, 0);
    hold(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) hold(0, 1, 0, 1);
    run("pingpong_narrow");
    abort = 1'b1;
    idle(0, 1);
    drain("narrow_abort", 1);
    abort = 1'b0;

    // amp=0 coerced, start during RUN ignored, cfg changes ignored
    launch(0, 200, 220, 10, 1, 0, 8'h5A);
    hold(200, 2, 0, 0); hold(210, 2, 1, 0); hold(220, 2, 1, 0);
    finish_rec(220);
    drain("cfg_latch", 1);
    cfg_freq_stop = 12'd1000; cfg_freq_step = 12'd1; cfg_dwell = 16'd5;
    cfg_amp = 3'd7; cfg_phase = 8'h00; cfg_mode = 2'd1;
    drain("cfg_latch", 3);
    check("amp_coerce", 32'(gen_amp), 32'd1);
    start = 1'b0;
    drain("cfg_latch", sb.size());
    check("phase_latch", 32'(gen_phase), 32'h5A);

    // Abort and start together in IDLE
    start = 1'b1; abort = 1'b1;
    idle(220, 1);
    drain("abort_beats_start", 1);
    start = 1'b0; abort = 1'b0;
    idle(220, 1);
    drain("abort_beats_start", 1);

    // Asynchronous reset mid-dwell
    launch(0, 300, 400, 10, 9, 5, 8'h33);
    hold(300, 3, 0, 0);
    run("pre_reset");
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", observed(), rec(0, 0, 0, 0, 0, 0));
    check("async_rst_amp", 32'(gen_amp), 32'd1);
    check("async_rst_phase", 32'(gen_phase), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(0, 3);
    drain("post_reset", 3);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
